fifo_wr_arb: RTL and testbench

Round-robin write-port arbiter for the 8-bit dual-clock FIFO. It sits in the 100 MHz write domain and shares the FIFO's single `wr_en`/`wr_data` port between `N_REQ` byte-stream sources. Each grant is a bounded burst. Throttling comes from the FIFO's `almost_full`/`full` flags. The block also keeps a running count of bytes written.

---
 rtl/fifo_wr_arb.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the FIFO write port between N_REQ byte-stream sources.
// Bounded bursts per grant, throttled by almost_full/full, with a saturating byte counter.
module fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk_100m,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   req_len,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     data_ack,
    output logic [N_REQ-1:0]     done,
    input  logic                 almost_full,
    input  logic                 full,
    output logic                 wr_en,
    output logic [7:0]           wr_data,
    output logic                 busy,
    output logic [15:0]          byte_cnt
);
    // state | meaning
    // IDLE  | waiting for any request; picks first requester at or after ptr
    // GRANT | grant shown, burst length latched and clamped, cnt cleared
    // XFER  | one byte per cycle while req held and FIFO has room
    // DONE  | done pulse, ptr moves just past the served requester
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

    state_t           state_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    sel_q;
    logic [3:0]       len_q;
    logic [3:0]       cnt_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic             busy_q;
    logic             wr_en_q;
    logic [7:0]       wr_data_q;
    logic [15:0]      byte_cnt_q;

    logic [PW-1:0]    pick_d;
    logic [PW-1:0]    scan_idx;
    logic [3:0]       len_raw;
    logic [3:0]       len_d;
    logic             sel_req;
    logic             ack;
    logic [N_REQ-1:0] sel_onehot;
    logic [7:0]       sel_data;

    // Scan downwards so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        pick_d   = ptr_q;
        scan_idx = ptr_q;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_idx = PW'((int'(ptr_q) + i) % N_REQ);
            if (req[scan_idx]) pick_d = scan_idx;
        end
    end

    assign sel_req    = req[sel_q];
    assign sel_data   = req_data[8*int'(sel_q) +: 8];
    assign len_raw    = req_len[4*int'(sel_q) +: 4];
    assign sel_onehot = N_REQ'(1) << sel_q;

    always_comb begin
        len_d = len_raw;
        if (len_raw == 4'd0) begin
            len_d = 4'd1;
        end else if (int'(len_raw) > MAX_BURST) begin
            len_d = 4'(MAX_BURST);
        end
    end

    // Gated by rst so a reset landing mid-burst consumes no further byte.
    assign ack      = ~rst & (state_q == XFER) & sel_req & ~almost_full & ~full;
    assign data_ack = ack ? sel_onehot : '0;

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        sel_q   <= pick_d;
                        gnt_q   <= N_REQ'(1) << pick_d;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    len_q   <= len_d;
                    cnt_q   <= '0;
                    state_q <= XFER;
                end
                XFER: begin
                    if (!sel_req) begin
                        gnt_q   <= '0;
                        done_q  <= sel_onehot;
                        state_q <= DONE;
                    end else if (ack) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == len_q) begin
                            gnt_q   <= '0;
                            done_q  <= sel_onehot;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    ptr_q   <= (sel_q == PW'(N_REQ - 1)) ? '0 : sel_q + PW'(1);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            wr_en_q <= ack;
            if (ack) wr_data_q <= sel_data;
            if (wr_en_q && (byte_cnt_q != 16'hFFFF)) byte_cnt_q <= byte_cnt_q + 16'd1;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: requester byte-stream model, write/done scoreboard
// checked by a negedge monitor, plus cycle-exact checks on grant, stall, abort and reset.
module tb_fifo_wr_arb;
    localparam int NR = 4;

    logic            clk_100m = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [4*NR-1:0] req_len;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   data_ack;
    logic [NR-1:0]   done;
    logic            almost_full;
    logic            full;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            busy;
    logic [15:0]     byte_cnt;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_wr[$];
    int         exp_done[$];
    int         exp_idx[NR];
    int         bidx[NR];
    logic       prev_ack = 1'b0;

    fifo_wr_arb #(.N_REQ(NR), .MAX_BURST(8)) dut (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .req_data   (req_data),
        .gnt        (gnt),
        .data_ack   (data_ack),
        .done       (done),
        .almost_full(almost_full),
        .full       (full),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .busy       (busy),
        .byte_cnt   (byte_cnt)
    );

    initial forever #5 clk_100m = ~clk_100m;

    // Byte k of requester i; requester 0 starts 11,22,33,44.
    function automatic logic [7:0] f(int i, int k);
        return 8'((k + 1) * 17 + i * 5);
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NR; i++) req_data[8*i +: 8] = f(i, bidx[i]);
    endtask

    // Requester model: an ack consumed at a posedge advances that stream just after it.
    initial begin
        logic [NR-1:0] a;
        drive_data();
        forever begin
            @(negedge clk_100m);
            a = data_ack;
            @(posedge clk_100m);
            #1;
            for (int i = 0; i < NR; i++) if (((a >> i) & 1) != 0) bidx[i]++;
            drive_data();
        end
    end

    always @(negedge clk_100m) begin
        logic [7:0] eb;
        int         ed;
        n_cmp++;
        if (wr_en !== prev_ack) begin
            n_err++;
            $display("FAIL wr_en_lag: wr_en=%0b, ack one cycle earlier=%0b", wr_en, prev_ack);
        end
        if (wr_en) begin
            n_cmp++;
            if (exp_wr.size() == 0) begin
                n_err++;
                $display("FAIL wr_data: unexpected write of %02h", wr_data);
            end else begin
                eb = exp_wr.pop_front();
                if (wr_data !== eb) begin
                    n_err++;
                    $display("FAIL wr_data: got %02h expected %02h", wr_data, eb);
                end
            end
        end
        if (|done) begin
            n_cmp++;
            if (exp_done.size() == 0) begin
                n_err++;
                $display("FAIL done: unexpected done=%b", done);
            end else begin
                ed = exp_done.pop_front();
                if (done !== NR'(1 << ed)) begin
                    n_err++;
                    $display("FAIL done: got %b expected requester %0d", done, ed);
                end
            end
        end
        if (|data_ack) begin
            n_cmp++;
            if (almost_full || full) begin
                n_err++;
                $display("FAIL ack_stall: data_ack=%b with almost_full=%0b full=%0b", data_ack, almost_full, full);
            end
        end
        prev_ack <= |data_ack;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic set_len(int i, int v);
        req_len[4*i +: 4] = 4'(v);
    endtask

    task automatic push_bytes(int i, int n);
        for (int k = 0; k < n; k++) begin
            exp_wr.push_back(f(i, exp_idx[i]));
            exp_idx[i]++;
        end
    endtask

    task automatic push_burst(int i, int n);
        push_bytes(i, n);
        exp_done.push_back(i);
    endtask

    task automatic wait_acks(int i, int n);
        int seen = 0;
        for (int c = 0; c < 200 && seen < n; c++) begin
            @(negedge clk_100m);
            if (((data_ack >> i) & 1) != 0) seen++;
        end
        if (seen < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_acks: requester %0d saw %0d acks, wanted %0d", i, seen, n);
        end
    endtask

    task automatic wait_done(int i);
        bit got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk_100m);
            got = ((done >> i) & 1) != 0;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done: no done from requester %0d, wanted one", i);
        end
    endtask

    task automatic drain(string name);
        repeat (4) tick();
        check({name, "_leftover"}, exp_wr.size() + exp_done.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        almost_full = 1'b0;
        full = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int ord[9] = '{0, 1, 3, 0, 1, 3, 0, 1, 2};
        int n;
        bit got;
        req_len = '0;
        do_reset();
        @(negedge clk_100m);
        check("reset_ctl", {gnt, data_ack, done, wr_en, busy}, 0);
        check("reset_data", {wr_data, byte_cnt}, 0);

        // single requester, cycle-exact timing
        tick();
        set_len(0, 4);
        push_burst(0, 4);
        req = 4'b0001;
        @(negedge clk_100m); check("gnt_T", gnt, 4'b0000);
        @(negedge clk_100m); check("gnt_T1", gnt, 4'b0001); check("busy_T1", busy, 1);
        @(negedge clk_100m); check("ack_T2", data_ack, 4'b0001);
        @(negedge clk_100m); check("wr_en_T3", wr_en, 1);
        repeat (3) @(negedge clk_100m);
        check("done_TL2", done, 4'b0001);
        check("gnt_off_TL2", gnt, 4'b0000);
        tick();
        req = '0;
        repeat (2) tick();
        @(negedge clk_100m);
        check("byte_cnt_4", byte_cnt, 4);
        check("busy_idle", busy, 0);
        drain("single");

        // round robin, then late requester 2
        do_reset();
        for (int i = 0; i < NR; i++) set_len(i, 2);
        for (int d = 0; d < 9; d++) push_burst(ord[d], 2);
        req = 4'b1011;
        for (int d = 0; d < 5; d++) wait_done(ord[d]);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk_100m);
            got = (gnt == 4'b1000);
        end
        check("rr_gnt3", got, 1);
        tick();
        req = 4'b1111;
        for (int d = 5; d < 9; d++) wait_done(ord[d]);
        tick();
        req = '0;
        drain("round_robin");

        // almost_full stall from the 3rd ack
        do_reset();
        set_len(0, 8);
        push_burst(0, 8);
        req = 4'b0001;
        wait_acks(0, 2);
        tick();
        almost_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_100m);
            check("af_stall_ack", data_ack, 0);
            tick();
        end
        almost_full = 1'b0;
        @(negedge clk_100m);
        check("af_resume_ack", data_ack, 4'b0001);
        n = 1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk_100m);
            got = done[0];
            if (data_ack[0]) n++;
        end
        check("acks_after_stall", n, 6);
        tick();
        req = '0;
        drain("flow");

        // length clamp 0 -> 1
        set_len(2, 0);
        push_burst(2, 1);
        req = 4'b0100;
        wait_done(2);
        tick();
        req = '0;
        drain("clamp0");

        // length clamp 12 -> 8, with a full stall after 4 acks
        set_len(2, 12);
        push_burst(2, 8);
        req = 4'b0100;
        wait_acks(2, 4);
        tick();
        full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_100m);
            check("full_stall_ack", data_ack, 0);
            tick();
        end
        full = 1'b0;
        wait_done(2);
        tick();
        req = '0;
        drain("clamp12");

        // abort after 3 acks, then ptr must sit at 2
        set_len(1, 6);
        push_bytes(1, 3);
        exp_done.push_back(1);
        req = 4'b0010;
        wait_acks(1, 3);
        tick();
        req = '0;
        @(negedge clk_100m); check("abort_no_ack", data_ack, 0);
        @(negedge clk_100m); check("abort_done", done, 4'b0010);
        tick();
        set_len(0, 2);
        set_len(2, 2);
        push_burst(2, 2);
        push_burst(0, 2);
        req = 4'b0101;
        wait_done(2);
        wait_done(0);
        tick();
        req = '0;
        drain("abort");

        // reset mid-XFER
        set_len(3, 8);
        push_bytes(3, 2);
        req = 4'b1000;
        wait_acks(3, 2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        @(negedge clk_100m);
        check("rst_mid_ctl", {gnt, data_ack, done, wr_en, busy}, 0);
        check("rst_mid_data", {wr_data, byte_cnt}, 0);
        tick();
        set_len(0, 2);
        set_len(3, 2);
        push_burst(0, 2);
        push_burst(3, 2);
        req = 4'b1001;
        wait_done(0);
        wait_done(3);
        tick();
        req = '0;
        drain("reset");

        // byte_cnt saturation from a preloaded count
        do_reset();
        @(negedge clk_100m);
        dut.byte_cnt_q = 16'hFFFA;
        tick();
        set_len(0, 8);
        push_burst(0, 8);
        req = 4'b0001;
        wait_done(0);
        tick();
        req = '0;
        repeat (2) tick();
        @(negedge clk_100m);
        check("byte_cnt_sat", byte_cnt, 16'hFFFF);
        drain("saturate");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
